// File: rtl/cci_mpf_vtp_arb_pkg.sv
// Shared types for the VTP service port arbiter: lookup request/response payloads,
// port index, credit and statistics counter types.
package cci_mpf_vtp_arb_pkg;

    localparam int unsigned VTP_ARB_MAX_PORTS       = 16;
    localparam int unsigned VTP_ARB_MAX_OUTSTANDING = 15;
    localparam int unsigned VTP_ARB_PORT_IDX_W      = $clog2(VTP_ARB_MAX_PORTS);
    localparam int unsigned VTP_ARB_CREDIT_W        = $clog2(VTP_ARB_MAX_OUTSTANDING + 1);
    localparam int unsigned VTP_ARB_STAT_W          = 32;

    localparam int unsigned VTP_VA_PAGE_W = 36;
    localparam int unsigned VTP_PA_PAGE_W = 34;
    localparam int unsigned VTP_TAG_W     = 8;

    typedef logic [VTP_ARB_PORT_IDX_W-1:0] t_vtp_arb_port_idx;
    typedef logic [VTP_ARB_CREDIT_W-1:0]   t_vtp_arb_credit;
    typedef logic [VTP_ARB_STAT_W-1:0]     t_vtp_arb_stat;

    typedef struct packed {
        logic [VTP_VA_PAGE_W-1:0] page_va;
        logic [VTP_TAG_W-1:0]     tag;
    } t_cci_mpf_shim_vtp_lookup_req;

    typedef struct packed {
        logic [VTP_PA_PAGE_W-1:0] page_pa;
        logic                     is_big_page;
        logic                     error;
        logic [VTP_TAG_W-1:0]     tag;
    } t_cci_mpf_shim_vtp_lookup_rsp;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic t_vtp_arb_stat vtp_arb_sat_inc(input t_vtp_arb_stat v);
        return (v == '1) ? v : v + t_vtp_arb_stat'(1);
    endfunction

endpackage

// File: rtl/cci_mpf_prim_arb_rr.sv
// N-way round-robin arbiter: one-hot grant starting at the pointer, pointer moves
// to winner+1 whenever a grant is issued.
module cci_mpf_prim_arb_rr #(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 ena,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] grant_idx_c
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr;
    logic [N-1:0]     hi_mask_c;
    logic [N-1:0]     masked_c;
    logic [N-1:0]     pick_c;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    always_comb begin
        hi_mask_c   = '0;
        grant_c     = '0;
        grant_idx_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask_c[i] = (IDX_W'(i) >= ptr);
        end
        masked_c = req & hi_mask_c;
        pick_c   = (|masked_c) ? masked_c : req;
        if (ena) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pick_c[i]) begin
                    grant_c     = '0;
                    grant_c[i]  = 1'b1;
                    grant_idx_c = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (|grant_c) begin
            ptr <= (grant_idx_c == IDX_W'(N - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/cci_mpf_svc_vtp_port_arb.sv
// Shares one VTP translation service among N client ports with round-robin grants and
// per-port credits. Optional statistics counters: define CCI_MPF_VTP_ARB_STATS_EN.
module cci_mpf_svc_vtp_port_arb
    import cci_mpf_vtp_arb_pkg::*;
#(
    parameter int unsigned N_VTP_PORTS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned DEBUG_MESSAGES  = 0
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [N_VTP_PORTS-1:0]                          cli_req_en,
    input  t_cci_mpf_shim_vtp_lookup_req [N_VTP_PORTS-1:0]  cli_req,
    output logic [N_VTP_PORTS-1:0]                          cli_req_rdy,
    output logic [N_VTP_PORTS-1:0]                          cli_rsp_valid,
    output t_cci_mpf_shim_vtp_lookup_rsp                    cli_rsp,
    output logic                                            svc_lookupEn,
    output t_cci_mpf_shim_vtp_lookup_req                    svc_lookupReq,
    output logic [$clog2(N_VTP_PORTS)-1:0]                  svc_reqPortIdx,
    input  logic                                            svc_lookupRdy,
    input  logic                                            svc_rspValid,
    input  t_cci_mpf_shim_vtp_lookup_rsp                    svc_rsp,
    input  logic [$clog2(N_VTP_PORTS)-1:0]                  svc_rspPortIdx,
    output logic                                            err_underflow,
    output t_vtp_arb_stat [N_VTP_PORTS-1:0]                 stat_grants,
    output t_vtp_arb_stat [N_VTP_PORTS-1:0]                 stat_stalls
);

    localparam int unsigned   IDX_W      = $clog2(N_VTP_PORTS);
    localparam t_vtp_arb_credit CREDIT_MAX = t_vtp_arb_credit'(MAX_OUTSTANDING);

    logic [N_VTP_PORTS-1:0] eligible_c;
    logic [N_VTP_PORTS-1:0] grant_c;
    logic [N_VTP_PORTS-1:0] rsp_hit_c;
    logic [N_VTP_PORTS-1:0] zero_c;
    logic [IDX_W-1:0]       grant_idx_c;
    logic                   can_load_c;
    logic                   out_valid;
    t_vtp_arb_credit        cnt [N_VTP_PORTS];

    assign svc_lookupEn = reset_n && out_valid && svc_lookupRdy;
    assign can_load_c   = reset_n && (!out_valid || svc_lookupEn);
    assign cli_req_rdy  = grant_c;

    always_comb begin
        eligible_c = '0;
        rsp_hit_c  = '0;
        zero_c     = '0;
        for (int unsigned i = 0; i < N_VTP_PORTS; i++) begin
            eligible_c[i] = cli_req_en[i] && (cnt[i] < CREDIT_MAX);
            rsp_hit_c[i]  = svc_rspValid && (svc_rspPortIdx == IDX_W'(i));
            zero_c[i]     = (cnt[i] == '0);
        end
    end

    cci_mpf_prim_arb_rr #(
        .N (N_VTP_PORTS)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (eligible_c),
        .ena         (can_load_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    // Single-entry output stage feeding the service input FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            svc_lookupReq  <= '0;
            svc_reqPortIdx <= '0;
        end else if (can_load_c) begin
            out_valid <= |grant_c;
            if (|grant_c) begin
                svc_lookupReq  <= cli_req[grant_idx_c];
                svc_reqPortIdx <= grant_idx_c;
            end
        end
    end

    // A grant and a response on the same port cancel out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_VTP_PORTS; i++) begin
                cnt[i] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_VTP_PORTS; i++) begin
                if (grant_c[i] && !rsp_hit_c[i]) begin
                    cnt[i] <= cnt[i] + t_vtp_arb_credit'(1);
                end else if (rsp_hit_c[i] && !grant_c[i] && !zero_c[i]) begin
                    cnt[i] <= cnt[i] - t_vtp_arb_credit'(1);
                end
            end
            err_underflow <= err_underflow || (|(rsp_hit_c & ~grant_c & zero_c));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cli_rsp_valid <= '0;
            cli_rsp       <= '0;
        end else begin
            cli_rsp_valid <= rsp_hit_c;
            cli_rsp       <= svc_rsp;
        end
    end

`ifdef CCI_MPF_VTP_ARB_STATS_EN
    t_vtp_arb_stat [N_VTP_PORTS-1:0] grants_q;
    t_vtp_arb_stat [N_VTP_PORTS-1:0] stalls_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_VTP_PORTS; i++) begin
                if (grant_c[i]) begin
                    grants_q[i] <= vtp_arb_sat_inc(grants_q[i]);
                end
                if (cli_req_en[i] && !grant_c[i]) begin
                    stalls_q[i] <= vtp_arb_sat_inc(stalls_q[i]);
                end
            end
        end
    end

    assign stat_grants = grants_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

    // Simulation trace of grants and responses.
    if (DEBUG_MESSAGES != 0) begin : g_debug
        always_ff @(posedge clk) begin
            if (reset_n && (|grant_c)) begin
                $display("VTP ARB: grant port %0d", grant_idx_c);
            end
            if (reset_n && svc_rspValid) begin
                $display("VTP ARB: response port %0d", svc_rspPortIdx);
            end
        end
    end

endmodule
